mdu_sched: RTL

//  Multi-cycle multiply/divide sequencer for the E stage of the 5-stage MIPS pipeline.
//  - Accepts one HI/LO operation per start pulse.
//  - Holds the result invisible for a fixed latency, counting down with busy asserted.
//  - Commits HI/LO when the count ends.
//  - Generates the D-stage stall request for mfhi/mflo/mult/div/mthi/mtlo that meet an active or starting operation.

---
 rtl/mdu_sched.sv | 125 ++++++++++++
 1 files changed

// File: rtl/mdu_sched.sv
// HI/LO multiply/divide sequencer for the E stage: computes the result at start,
// hides it for a fixed busy latency, then commits HI/LO and drives the D-stage stall.
module mdu_sched #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10,
   parameter int CNT_W       = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  md_op,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        d_hilo_use,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        stall_md,
   output logic        state_dbg
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

   // Handshake: start is a one-cycle valid with no ready; the pipeline must honour
   // stall_md, so a start that arrives while busy is dropped.
   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic [31:0]       hi_nx, lo_nx;
   logic [31:0]       pend_hi, pend_lo, pend_hi_nx, pend_lo_nx;
   logic              start_md;
   logic [63:0]       res;
   logic [63:0]       sx_rs, sx_rt, zx_rs, zx_rt;
   logic [31:0]       div_safe, uq, ur;
   logic signed [31:0] s_rs, s_dv, s_q, s_r;

   assign start_md  = start && (md_op >= 3'd1) && (md_op <= 3'd4);
   assign busy      = (state == RUN);
   assign stall_md  = d_hilo_use & (busy | start_md);
   assign state_dbg = state;

   // Divide-by-zero substitutes 1 so no X escapes; the result is discarded anyway.
   always_comb begin
      sx_rs    = {{32{rs_val[31]}}, rs_val};
      sx_rt    = {{32{rt_val[31]}}, rt_val};
      zx_rs    = {32'd0, rs_val};
      zx_rt    = {32'd0, rt_val};
      div_safe = (rt_val == 32'd0) ? 32'd1 : rt_val;
      uq       = rs_val / div_safe;
      ur       = rs_val % div_safe;
      s_rs     = rs_val;
      s_dv     = div_safe;
      s_q      = s_rs / s_dv;
      s_r      = s_rs % s_dv;
      res      = {hi, lo};
      case (md_op)
         3'd1: res = sx_rs * sx_rt;
         3'd2: res = zx_rs * zx_rt;
         3'd3: begin
            if (rt_val == 32'd0)
               res = {hi, lo};
            else if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF)
               res = {32'd0, 32'h8000_0000};
            else
               res = {s_r, s_q};
         end
         3'd4: res = (rt_val == 32'd0) ? {hi, lo} : {ur, uq};
         default: res = {hi, lo};
      endcase
   end

   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      hi_nx      = hi;
      lo_nx      = lo;
      pend_hi_nx = pend_hi;
      pend_lo_nx = pend_lo;
      case (state)
         IDLE: begin
            if (start_md) begin
               state_nx   = RUN;
               cnt_nx     = (md_op <= 3'd2) ? MULT_N : DIV_N;
               pend_hi_nx = res[63:32];
               pend_lo_nx = res[31:0];
            end else if (start && md_op == 3'd5) begin
               hi_nx = rs_val;
            end else if (start && md_op == 3'd6) begin
               lo_nx = rs_val;
            end
         end
         RUN: begin
            if (cnt == CNT_W'(1)) begin
               hi_nx    = pend_hi;
               lo_nx    = pend_lo;
               cnt_nx   = '0;
               state_nx = IDLE;
            end else begin
               cnt_nx = cnt - CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         hi      <= hi_nx;
         lo      <= lo_nx;
         pend_hi <= pend_hi_nx;
         pend_lo <= pend_lo_nx;
      end
   end

endmodule
